mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data-port wins with fetch waiting before fetch is forced through (range 1..7).
REQ-002 clk  in  1  system clock; all state on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 f_valid  in  1  fetch request valid; f_addr  in  32  byte address of a word read.
REQ-005 f_ready  out  1  fetch request accepted this cycle.
REQ-006 f_rsp_valid  out  1  fetch read data valid; f_rsp_data  out  32  fetched word.
REQ-007 d_valid  in  1  data request valid; d_we  in  1  1=store, 0=load.
REQ-008 d_addr  in  32  byte address; d_wdata  in  32  store data, low-aligned.
REQ-009 d_mode  in  2  access size: 0 byte, 1 halfword, 2 word; d_signed  in  1  sign-extend load.
REQ-010 d_ready  out  1  data request accepted this cycle.
REQ-011 d_rsp_valid  out  1  data response; d_rsp_data  out  32  load result (0 for stores); d_rsp_err  out  1  misaligned/illegal.
REQ-012 ram_we  out  1; ram_r_addr, ram_w_addr  out  32; ram_w_data  out  32; ram_write_mode, ram_read_mode  out  2; ram_read_signed  out  1  memory port drive.
REQ-013 ram_r_data  in  32  memory read data, valid one cycle after address issue.

Function
REQ-014 A request transfers in cycle T when valid and ready are both 1 in T; ready SHALL be combinational and never depend on its own valid.
REQ-015 At most one request (fetch or data) SHALL transfer per cycle; the other ready SHALL be 0.
REQ-016 Arbiter FSM states: D_PRI (reset) and F_PRI.
REQ-017 D_PRI: data wins if d_valid, else fetch wins if f_valid.
REQ-018 Starvation counter increments when data wins while f_valid=1, clears when fetch wins or f_valid=0; reaching STARVE_LIMIT moves FSM to F_PRI.
REQ-019 F_PRI: fetch wins if f_valid, else data if d_valid; after any grant or a cycle with f_valid=0, return to D_PRI and clear counter.
REQ-020 Fetch grant: ram_r_addr=f_addr, ram_read_mode=2, ram_read_signed=0, ram_we=0.
REQ-021 Data load grant: ram_r_addr=d_addr, ram_read_mode=d_mode, ram_read_signed=d_signed, ram_we=0.
REQ-022 Data store grant: ram_we=1, ram_w_addr=d_addr, ram_w_data=d_wdata, ram_write_mode=d_mode.
REQ-023 Misaligned data request (word with addr[1:0]!=0, half with addr[1:0]=3, or d_mode=3) SHALL be accepted without RAM access (ram_we=0) and flagged as error.
REQ-024 Fetch with f_addr[1:0]!=0 SHALL be issued with addr[1:0] forced to 0.
REQ-025 When no grant: ram_we=0; other RAM outputs don't-care but SHALL hold last values.
REQ-026 Latency: request accepted in T produces exactly one response pulse in T+1 on the owning port; rsp_data=ram_r_data for reads.
REQ-027 Stores SHALL respond in T+1 with d_rsp_data=0, d_rsp_err=0; errors respond in T+1 with d_rsp_data=0, d_rsp_err=1.
REQ-028 One-bit owner tag and pending flags SHALL be registered at T; back-to-back grants every cycle sustain full throughput.
REQ-029 Responses have no backpressure; requesters SHALL accept them.
REQ-030 Response data outputs SHALL be 0 when the corresponding rsp_valid is 0.

Reset
REQ-031 rst asserted: FSM=D_PRI, counter=0, pending flags cleared immediately; f_rsp_valid, d_rsp_valid, d_rsp_err, rsp_data=0; ram_we=0.
REQ-032 Reset mid-operation SHALL drop any in-flight response; no response pulses in the cycle after rst deasserts.
REQ-033 ready outputs SHALL be 0 while rst=1.

Verification
REQ-034 Fetch only, f_addr=0x10 -> f_ready=1, next cycle f_rsp_valid=1, f_rsp_data=mem word 4.
REQ-035 d_valid and f_valid held high, loads every cycle, STARVE_LIMIT=4 -> 4 data grants, 1 fetch grant, pattern repeats; no response lost.
REQ-036 Store byte 0xAB at 0x21, then load byte signed at 0x21 -> load response 0xFFFFFFAB one cycle after its grant.
REQ-037 Load word at 0x22 -> ram_we=0, next cycle d_rsp_valid=1, d_rsp_err=1, d_rsp_data=0.
REQ-038 Assert rst the cycle after a load grant -> no d_rsp_valid, FSM=D_PRI, counter=0 after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-ported RAM: data-priority with a
// starvation escape for fetch, one-cycle response return to the owning port.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic [31:0] f_addr,
  output logic        f_ready,
  output logic        f_rsp_valid,
  output logic [31:0] f_rsp_data,
  input  logic        d_valid,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_mode,
  input  logic        d_signed,
  output logic        d_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic        ram_we,
  output logic [31:0] ram_r_addr,
  output logic [31:0] ram_w_addr,
  output logic [31:0] ram_w_data,
  output logic [1:0]  ram_write_mode,
  output logic [1:0]  ram_read_mode,
  output logic        ram_read_signed,
  input  logic [31:0] ram_r_data
);

  typedef enum logic {D_PRI, F_PRI} arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  mode;
    logic        sgn;
  } rd_port_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  mode;
  } wr_port_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  arb_state_e state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       f_grant, d_grant, ld_grant, st_grant, d_err;
  rd_port_t   rd_q, rd_n;
  wr_port_t   wr_q, wr_n;
  logic       f_pend, d_pend, d_ld_q, d_err_q;

  assign d_err = (d_mode == 2'd3) ||
                 (d_mode == 2'd2 && d_addr[1:0] != 2'd0) ||
                 (d_mode == 2'd1 && d_addr[1:0] == 2'd3);

  // Each ready looks only at the other side's valid, so neither loops on itself.
  always_comb begin
    f_ready = 1'b0;
    d_ready = 1'b0;
    if (!rst) begin
      case (state)
        D_PRI: begin
          d_ready = 1'b1;
          f_ready = !d_valid;
        end
        F_PRI: begin
          f_ready = 1'b1;
          d_ready = !f_valid;
        end
        default: ;
      endcase
    end
  end

  assign f_grant  = f_valid & f_ready;
  assign d_grant  = d_valid & d_ready;
  assign ld_grant = d_grant & !d_we & !d_err;
  assign st_grant = d_grant &  d_we & !d_err;

  // F_PRI always resolves in one cycle: fetch wins or fetch was idle.
  always_comb begin
    state_n = D_PRI;
    cnt_n   = 3'd0;
    if (state == D_PRI && d_grant && f_valid) begin
      if (cnt + 3'd1 >= LIMIT) state_n = F_PRI;
      else                     cnt_n   = cnt + 3'd1;
    end
  end

  // RAM port fields hold their last issued values between grants.
  always_comb begin
    rd_n = rd_q;
    wr_n = wr_q;
    if (f_grant)
      rd_n = '{addr: f_addr & 32'hFFFF_FFFC, mode: 2'd2, sgn: 1'b0};
    else if (ld_grant)
      rd_n = '{addr: d_addr, mode: d_mode, sgn: d_signed};
    if (st_grant)
      wr_n = '{addr: d_addr, data: d_wdata, mode: d_mode};
  end

  assign ram_we          = st_grant;
  assign ram_r_addr      = rd_n.addr;
  assign ram_read_mode   = rd_n.mode;
  assign ram_read_signed = rd_n.sgn;
  assign ram_w_addr      = wr_n.addr;
  assign ram_w_data      = wr_n.data;
  assign ram_write_mode  = wr_n.mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= D_PRI;
      cnt     <= 3'd0;
      rd_q    <= '0;
      wr_q    <= '0;
      f_pend  <= 1'b0;
      d_pend  <= 1'b0;
      d_ld_q  <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      f_pend  <= f_grant;
      d_pend  <= d_grant;
      d_ld_q  <= ld_grant;
      d_err_q <= d_grant & d_err;
    end
  end

  // Stores and errors return zero data; only loads forward the RAM word.
  assign f_rsp_valid = f_pend;
  assign f_rsp_data  = f_pend ? ram_r_data : 32'd0;
  assign d_rsp_valid = d_pend;
  assign d_rsp_data  = d_ld_q ? ram_r_data : 32'd0;
  assign d_rsp_err   = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array RAM model plus a history-based reference
// for arbitration, RAM drive and responses, with directed and random steps.
module tb_mem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_valid = 1'b0, d_valid = 1'b0, d_we = 1'b0, d_signed = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0]  d_mode = '0;
  logic        f_ready, f_rsp_valid, d_ready, d_rsp_valid, d_rsp_err;
  logic [31:0] f_rsp_data, d_rsp_data;
  logic        ram_we, ram_read_signed;
  logic [31:0] ram_r_addr, ram_w_addr, ram_w_data, ram_r_data;
  logic [1:0]  ram_write_mode, ram_read_mode;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_mode(d_mode), .d_signed(d_signed), .d_ready(d_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .ram_we(ram_we), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data), .ram_write_mode(ram_write_mode),
    .ram_read_mode(ram_read_mode), .ram_read_signed(ram_read_signed),
    .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  logic [7:0] ram_mem [0:255];
  logic [7:0] ref_mem [0:255];

  function automatic logic [31:0] fmt(input logic [7:0] b0, b1, b2, b3,
                                      input logic [1:0] m, input logic s);
    case (m)
      2'd0:    return s ? {{24{b0[7]}}, b0} : {24'd0, b0};
      2'd1:    return s ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // Environment RAM: registered read, byte-lane writes, little-endian.
  always @(posedge clk) begin
    ram_r_data <= fmt(ram_mem[ram_r_addr[7:0]], ram_mem[8'(ram_r_addr[7:0] + 8'd1)],
                      ram_mem[8'(ram_r_addr[7:0] + 8'd2)], ram_mem[8'(ram_r_addr[7:0] + 8'd3)],
                      ram_read_mode, ram_read_signed);
    if (ram_we) begin
      ram_mem[ram_w_addr[7:0]] <= ram_w_data[7:0];
      if (ram_write_mode != 2'd0) ram_mem[8'(ram_w_addr[7:0] + 8'd1)] <= ram_w_data[15:8];
      if (ram_write_mode == 2'd2) begin
        ram_mem[8'(ram_w_addr[7:0] + 8'd2)] <= ram_w_data[23:16];
        ram_mem[8'(ram_w_addr[7:0] + 8'd3)] <= ram_w_data[31:24];
      end
    end
  end

  function automatic logic [31:0] rd_ref(input logic [31:0] addr, input logic [1:0] m,
                                         input logic s);
    logic [7:0] a;
    a = addr[7:0];
    return fmt(ref_mem[a], ref_mem[8'(a + 8'd1)], ref_mem[8'(a + 8'd2)],
               ref_mem[8'(a + 8'd3)], m, s);
  endfunction

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference state: streak of consecutive data wins with fetch waiting,
  // the response owed next cycle, and the last values put on each RAM port.
  int          streak = 0;
  bit          e_fv = 0, e_dv = 0, e_derr = 0;
  logic [31:0] e_fd = '0, e_dd = '0;
  bit          r_known = 0, w_known = 0;
  logic [31:0] h_raddr, h_waddr, h_wdata;
  logic [1:0]  h_rmode, h_wmode;
  logic        h_rsgn;
  bit          fg, dg;

  task automatic cyc(input bit r, input bit fv, input logic [31:0] fa,
                     input bit dv, input bit dwe, input logic [31:0] da,
                     input logic [31:0] dwd, input logic [1:0] dm, input bit ds,
                     output bit f_g, output bit d_g);
    bit fpri, efr, edr, err, st, ld;
    @(negedge clk);
    rst = r; f_valid = fv; f_addr = fa; d_valid = dv; d_we = dwe;
    d_addr = da; d_wdata = dwd; d_mode = dm; d_signed = ds;
    #1;
    if (r) begin
      e_fv = 0; e_dv = 0; e_derr = 0; r_known = 0; w_known = 0;
    end
    chk("f_rsp_valid", {31'd0, f_rsp_valid}, {31'd0, e_fv});
    chk("f_rsp_data", f_rsp_data, e_fv ? e_fd : 32'd0);
    chk("d_rsp_valid", {31'd0, d_rsp_valid}, {31'd0, e_dv});
    chk("d_rsp_data", d_rsp_data, e_dv ? e_dd : 32'd0);
    chk("d_rsp_err", {31'd0, d_rsp_err}, {31'd0, e_derr});

    fpri = (streak >= LIM);
    if (r)         begin efr = 0; edr = 0;   end
    else if (fpri) begin efr = 1; edr = !fv; end
    else           begin edr = 1; efr = !dv; end
    chk("f_ready", {31'd0, f_ready}, {31'd0, efr});
    chk("d_ready", {31'd0, d_ready}, {31'd0, edr});
    chk("one_xfer", {31'd0, f_valid & f_ready & d_valid & d_ready}, 32'd0);
    f_g = fv & efr;
    d_g = dv & edr;

    err = (dm == 2'd3) || (dm == 2'd2 && da[1:0] != 2'd0) || (dm == 2'd1 && da[1:0] == 2'd3);
    st = d_g & dwe & !err;
    ld = d_g & !dwe & !err;
    if (f_g) begin
      h_raddr = {fa[31:2], 2'b00}; h_rmode = 2'd2; h_rsgn = 1'b0; r_known = 1;
    end else if (ld) begin
      h_raddr = da; h_rmode = dm; h_rsgn = ds; r_known = 1;
    end
    if (st) begin
      h_waddr = da; h_wdata = dwd; h_wmode = dm; w_known = 1;
    end
    chk("ram_we", {31'd0, ram_we}, {31'd0, st});
    if (r_known) begin
      chk("ram_r_addr", ram_r_addr, h_raddr);
      chk("ram_read_mode", {30'd0, ram_read_mode}, {30'd0, h_rmode});
      chk("ram_read_signed", {31'd0, ram_read_signed}, {31'd0, h_rsgn});
    end
    if (w_known) begin
      chk("ram_w_addr", ram_w_addr, h_waddr);
      chk("ram_w_data", ram_w_data, h_wdata);
      chk("ram_write_mode", {30'd0, ram_write_mode}, {30'd0, h_wmode});
    end

    e_fv = f_g;
    e_fd = rd_ref({fa[31:2], 2'b00}, 2'd2, 1'b0);
    e_dv = d_g;
    e_derr = d_g & err;
    e_dd = ld ? rd_ref(da, dm, ds) : 32'd0;
    if (st) begin
      ref_mem[da[7:0]] = dwd[7:0];
      if (dm != 2'd0) ref_mem[8'(da[7:0] + 8'd1)] = dwd[15:8];
      if (dm == 2'd2) begin
        ref_mem[8'(da[7:0] + 8'd2)] = dwd[23:16];
        ref_mem[8'(da[7:0] + 8'd3)] = dwd[31:24];
      end
    end

    if (r || f_g || !fv) streak = 0;
    else if (d_g)        streak++;
  endtask

  initial begin
    int nf;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      ram_mem[i] <= b;
      ref_mem[i] = b;
    end

    // reset state, with requests offered that must not be taken
    cyc(1, 1, 32'h40, 1, 0, 32'h44, 0, 2'd2, 0, fg, dg);
    cyc(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, fg, dg);

    // fetch only at 0x10
    cyc(0, 1, 32'h10, 0, 0, 0, 0, 2'd0, 0, fg, dg);
    chk("fetch_grant", {31'd0, fg}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, fg, dg);
    chk("fetch_word4", f_rsp_data,
        {ref_mem[8'h13], ref_mem[8'h12], ref_mem[8'h11], ref_mem[8'h10]});

    // misaligned fetch is issued word-aligned
    cyc(0, 1, 32'h1237, 0, 0, 0, 0, 2'd0, 0, fg, dg);
    chk("fetch_align", ram_r_addr, 32'h1234);

    // store byte then signed byte load
    cyc(0, 0, 0, 1, 1, 32'h21, 32'h1234_56AB, 2'd0, 0, fg, dg);
    cyc(0, 0, 0, 1, 0, 32'h21, 0, 2'd0, 1, fg, dg);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, fg, dg);
    chk("ld_byte_sext", d_rsp_data, 32'hFFFF_FFAB);

    // misaligned word load and illegal mode
    cyc(0, 0, 0, 1, 0, 32'h22, 0, 2'd2, 0, fg, dg);
    chk("mis_no_we", {31'd0, ram_we}, 32'd0);
    cyc(0, 0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF, 2'd3, 0, fg, dg);
    chk("mis_err", {31'd0, d_rsp_err}, 32'd1);
    chk("mis_data", d_rsp_data, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, fg, dg);
    chk("mode3_err", {31'd0, d_rsp_err}, 32'd1);

    // both sides saturated: four data wins then one fetch, repeating
    nf = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(0, 1, $urandom, 1, 0, {$urandom, 2'b00}, 0, 2'd2, 0, fg, dg);
      chk("starve_pat", {31'd0, fg}, {31'd0, (i % 5) == 4});
      nf += int'(fg);
    end
    chk("starve_cnt", nf, 5);

    // reset right after a load grant drops its response and restarts arbitration
    cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, fg, dg);
    cyc(0, 0, 0, 1, 0, 32'h30, 0, 2'd2, 0, fg, dg);
    cyc(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, fg, dg);
    chk("rst_drop", {31'd0, d_rsp_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, {$urandom, 2'b00}, 1, 0, {$urandom, 2'b00}, 0, 2'd2, 0, fg, dg);
      chk("post_rst_pat", {31'd0, fg}, {31'd0, i == 4});
    end

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom,
          $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom,
          $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, fg, dg);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, fg, dg);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
